time_disp_sched: RTL and testbench
==================================

Name: time_disp_sched

Overview:
- Scheduler that shares one serial 6-bit binary-to-BCD converter between the hour, minute and second fields of the hh-mm-ss display path.
- Detects value changes, converts the three fields in sequence on the shared converter, then commits all eight display digits at once.
- Applies set-mode blinking to one selected field.
- Sits between the time counter and the 8-digit common-anode scan driver, and replaces three parallel converters.

Parameters:
- SEP_CODE, 4'd11, digit code for '-' on bit_5 and bit_2.
- BLANK_CODE, 4'd10, digit code for a blank digit.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-low
- hour  in  6  binary hour, 0..23 (any 0..63 must convert correctly)
- minute  in  6  binary minute
- second  in  6  binary second
- blink_en  in  1  set-mode enable
- blink_sel  in  2  field to blink: 0=second, 1=minute, 2=hour, 3=none
- blink_tick  in  1  one-cycle pulse; toggles blink phase
- bit_7..bit_0  out  4 each  digit codes, left to right: H1 H0 - M1 M0 - S1 S0
- busy  out  1  frame in progress
- frame_done  out  1  one-cycle pulse when the digits are committed

Behaviour:
- Reset (async, rst=0): all bit_* = BLANK_CODE, busy=0, frame_done=0, snapshot registers cleared, pending=1, blink phase=on, FSM=IDLE, converter idle.
- Interface: one clock, clk. Reset rst is asynchronous and active-low.
- FSM states:
  - IDLE
  - START: conv_start=1 for 1 cycle, operand = latched field
  - WAIT: until conv_done
  - STORE: latch tens/ones of the current field, advance field pointer s->m->h
  - COMMIT
- IDLE -> START when pending=1, or when {hour,minute,second} != last-converted snapshot. On this transition all three inputs are latched (coherent frame) and pending is cleared.
- Field order: second, minute, hour.
- After storing the hour field: STORE -> COMMIT -> IDLE. Otherwise STORE -> START.
- Converter latency: conv_start in cycle t; load in t+1; six iterations of (add-3 check on each nibble >4, then shift left 1), cycles t+1..t+12; conv_done high and result valid in t+13.
- Frame timing, with cycle 0 = first conv_start:
  - starts at cycles 0, 14, 28; converter dones at 13, 27, 41
  - COMMIT in cycle 42: digits, snapshot and frame_done registered, visible in cycle 43
  - busy=1 from cycle 0 through cycle 42
- Digit map: bit_7/6 = hour tens/ones; bit_4/3 = minute; bit_1/0 = second; bit_5 = bit_2 = SEP_CODE.
- Inputs changing mid-frame: the current frame completes with the latched values. The change is caught by the snapshot compare in IDLE, and a new frame starts the cycle after COMMIT.
- Blink:
  - blink_tick toggles the phase.
  - A rising edge of blink_en forces phase=on.
  - While blink_en=1 and phase=off, both digits of the field chosen by blink_sel are output as BLANK_CODE.
  - The overlay is registered: 1-cycle latency from a phase/enable/sel change to the outputs. It acts on the committed values and does not wait for a frame.
  - Separators are never blanked.
- blink_tick coinciding with a blink_en rise: the forced on wins.
- Reset mid-frame: abort immediately, return to reset values, start a fresh frame after reset release.

Decomposition:
- Package time_disp_pkg holds:
  - FSM state encoding
  - field index constants (FLD_SEC=0, FLD_MIN=1, FLD_HOUR=2)
  - BLANK_CODE/SEP_CODE defaults
  - converter latency constant CONV_LAT=13
- Sub-module bin6_bcd_serial:
  - ports: clk, rst, start, bin[5:0], tens[3:0], ones[3:0], busy, done
  - 14-bit shift register with add-3 adjust
  - start is ignored while busy

Test Plan:
- Reset release with h=12, m=34, s=56 -> first frame auto-starts; in cycle 43 digits = 1,2,11,3,4,11,5,6, frame_done pulses once, busy low from cycle 43.
- Steady inputs for 200 cycles after the first frame -> no further conv_start, busy stays 0.
- Change s 59->0 during frame cycle 20 (frame values h=23, m=59, s=59) -> frame commits 2,3,11,5,9,11,5,9. A second frame starts immediately and commits ...,0,0.
- Boundary value 63 on second -> bit_1=6, bit_0=3. Value 0 -> 0,0. Value 9 -> 0,9.
- blink_en=1, blink_sel=1, tick pulse -> bit_4 and bit_3 = 10 one cycle later, other digits unchanged. Next tick restores them. blink_sel=3 -> nothing blanks.
- Assert rst in cycle 20 of a frame -> all digits = 10 and busy=0 immediately. After release, a full frame commits the current inputs.

Source files
------------

// File: rtl/time_disp_pkg.sv
// Shared definitions for the hh-mm-ss display scheduler: FSM encoding,
// field indices, default digit codes and converter timing.
package time_disp_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_WAIT,
        ST_STORE,
        ST_COMMIT
    } sched_state_t;

    localparam logic [1:0] FLD_SEC  = 2'd0;
    localparam logic [1:0] FLD_MIN  = 2'd1;
    localparam logic [1:0] FLD_HOUR = 2'd2;

    localparam logic [3:0] BLANK_CODE_DEF = 4'd10;
    localparam logic [3:0] SEP_CODE_DEF   = 4'd11;

    // Cycles from conv_start to conv_done (done is high in cycle start+13).
    localparam int CONV_LAT = 13;
    // Six bits, each taking an adjust cycle and a shift cycle.
    localparam int CONV_STEPS = 12;

    // Double-dabble correction: a BCD nibble above 4 would overflow on the
    // next shift, so pre-add 3.
    function automatic logic [3:0] add3(input logic [3:0] n);
        return (n > 4'd4) ? (n + 4'd3) : n;
    endfunction

endpackage

// File: rtl/bin6_bcd_serial.sv
// Serial 6-bit binary to two-digit BCD converter. One start loads the
// operand; the next twelve cycles alternate adjust and shift; done pulses
// with the result valid one cycle after the last shift.
module bin6_bcd_serial
    import time_disp_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [5:0] bin,
    output logic [3:0] tens,
    output logic [3:0] ones,
    output logic       busy,
    output logic       done
);

    // {tens, ones, binary remainder}
    logic [13:0] sr_reg;
    logic [3:0]  step_reg;
    logic        busy_reg;
    logic        done_reg;

    // Load on start when idle, then run the adjust/shift sequence.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sr_reg   <= '0;
            step_reg <= '0;
            busy_reg <= 1'b0;
            done_reg <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            if (!busy_reg) begin
                if (start) begin
                    sr_reg   <= {8'd0, bin};
                    step_reg <= '0;
                    busy_reg <= 1'b1;
                end
            end else begin
                if (step_reg[0] == 1'b0) begin
                    sr_reg <= {add3(sr_reg[13:10]), add3(sr_reg[9:6]), sr_reg[5:0]};
                end else begin
                    sr_reg <= {sr_reg[12:0], 1'b0};
                end
                if (step_reg == 4'(CONV_STEPS - 1)) begin
                    busy_reg <= 1'b0;
                    done_reg <= 1'b1;
                end
                step_reg <= step_reg + 4'd1;
            end
        end
    end

    assign tens = sr_reg[13:10];
    assign ones = sr_reg[9:6];
    assign busy = busy_reg;
    assign done = done_reg;

endmodule

// File: rtl/time_disp_sched.sv
// Display scheduler: converts second, minute and hour on one shared serial
// BCD converter, commits all eight digits together, and overlays set-mode
// blinking on the committed digits.
module time_disp_sched
    import time_disp_pkg::*;
#(
    parameter logic [3:0] SEP_CODE   = SEP_CODE_DEF,
    parameter logic [3:0] BLANK_CODE = BLANK_CODE_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] hour,
    input  logic [5:0] minute,
    input  logic [5:0] second,
    input  logic       blink_en,
    input  logic [1:0] blink_sel,
    input  logic       blink_tick,
    output logic [3:0] bit_7,
    output logic [3:0] bit_6,
    output logic [3:0] bit_5,
    output logic [3:0] bit_4,
    output logic [3:0] bit_3,
    output logic [3:0] bit_2,
    output logic [3:0] bit_1,
    output logic [3:0] bit_0,
    output logic       busy,
    output logic       frame_done
);

    sched_state_t state_reg, state_next;
    logic [1:0]   fld_reg, fld_next;
    logic [3:0]   wait_reg, wait_next;

    logic         pending_reg;
    logic [5:0]   lat_h_reg, lat_m_reg, lat_s_reg;
    logic [5:0]   snap_h_reg, snap_m_reg, snap_s_reg;
    logic [11:0]  fld_tens_reg, fld_ones_reg;
    logic [31:0]  com_reg, com_next;
    logic [31:0]  disp_reg, disp_next;
    logic         frame_done_reg;
    logic         phase_reg, phase_next;
    logic         blink_en_d_reg;

    logic         frame_start, conv_start, do_store, do_commit;
    logic [5:0]   conv_bin;
    logic [3:0]   conv_tens, conv_ones;
    logic         conv_busy, conv_done;

    bin6_bcd_serial u_conv (
        .clk   (clk),
        .rst   (rst),
        .start (conv_start),
        .bin   (conv_bin),
        .tens  (conv_tens),
        .ones  (conv_ones),
        .busy  (conv_busy),
        .done  (conv_done)
    );

    // Operand for the converter is the latched copy of the current field.
    always_comb begin
        conv_bin = lat_h_reg;
        case (fld_reg)
            FLD_SEC: conv_bin = lat_s_reg;
            FLD_MIN: conv_bin = lat_m_reg;
            default: conv_bin = lat_h_reg;
        endcase
    end

    // Next-state and control strobes. WAIT is sized so STORE lands on the
    // converter's done cycle, giving back-to-back starts every 14 cycles.
    always_comb begin
        state_next  = state_reg;
        fld_next    = fld_reg;
        wait_next   = wait_reg;
        frame_start = 1'b0;
        conv_start  = 1'b0;
        do_store    = 1'b0;
        do_commit   = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (pending_reg ||
                    ({hour, minute, second} != {snap_h_reg, snap_m_reg, snap_s_reg})) begin
                    frame_start = 1'b1;
                    fld_next    = FLD_SEC;
                    state_next  = ST_START;
                end
            end
            ST_START: begin
                conv_start = 1'b1;
                wait_next  = '0;
                state_next = ST_WAIT;
            end
            ST_WAIT: begin
                wait_next = wait_reg + 4'd1;
                if (wait_reg == 4'(CONV_LAT - 2)) begin
                    state_next = ST_STORE;
                end
            end
            ST_STORE: begin
                do_store = 1'b1;
                if (fld_reg == FLD_HOUR) begin
                    state_next = ST_COMMIT;
                end else begin
                    fld_next   = fld_reg + 2'd1;
                    state_next = ST_START;
                end
            end
            ST_COMMIT: begin
                do_commit  = 1'b1;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // FSM state, field pointer and wait counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= ST_IDLE;
            fld_reg   <= FLD_SEC;
            wait_reg  <= '0;
        end else begin
            state_reg <= state_next;
            fld_reg   <= fld_next;
            wait_reg  <= wait_next;
        end
    end

    // Coherent input capture at frame start; snapshot of what was displayed.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pending_reg <= 1'b1;
            lat_h_reg   <= '0;
            lat_m_reg   <= '0;
            lat_s_reg   <= '0;
            snap_h_reg  <= '0;
            snap_m_reg  <= '0;
            snap_s_reg  <= '0;
        end else begin
            if (frame_start) begin
                pending_reg <= 1'b0;
                lat_h_reg   <= hour;
                lat_m_reg   <= minute;
                lat_s_reg   <= second;
            end
            if (do_commit) begin
                snap_h_reg <= lat_h_reg;
                snap_m_reg <= lat_m_reg;
                snap_s_reg <= lat_s_reg;
            end
        end
    end

    // Per-field BCD result storage, written on the converter's done cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fld_tens_reg <= '0;
            fld_ones_reg <= '0;
        end else if (do_store && conv_done) begin
            case (fld_reg)
                FLD_SEC: begin
                    fld_tens_reg[3:0] <= conv_tens;
                    fld_ones_reg[3:0] <= conv_ones;
                end
                FLD_MIN: begin
                    fld_tens_reg[7:4] <= conv_tens;
                    fld_ones_reg[7:4] <= conv_ones;
                end
                default: begin
                    fld_tens_reg[11:8] <= conv_tens;
                    fld_ones_reg[11:8] <= conv_ones;
                end
            endcase
        end
    end

    // All eight digits change together at commit.
    always_comb begin
        com_next = com_reg;
        if (do_commit) begin
            com_next = {fld_tens_reg[11:8], fld_ones_reg[11:8], SEP_CODE,
                        fld_tens_reg[7:4],  fld_ones_reg[7:4],  SEP_CODE,
                        fld_tens_reg[3:0],  fld_ones_reg[3:0]};
        end
    end

    // Blink phase: an enable rising edge forces on and overrides a tick.
    always_comb begin
        phase_next = phase_reg;
        if (blink_en && !blink_en_d_reg) begin
            phase_next = 1'b1;
        end else if (blink_tick) begin
            phase_next = ~phase_reg;
        end
    end

    // Blink overlay per digit; separators are never blanked.
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_digit
            localparam logic       IS_SEP = (gi == 2) || (gi == 5);
            localparam logic [1:0] FIELD  = (gi >= 6) ? FLD_HOUR :
                                            (gi >= 3) ? FLD_MIN  : FLD_SEC;
            assign disp_next[gi*4 +: 4] =
                (!IS_SEP && blink_en && !phase_next && (blink_sel == FIELD)) ?
                BLANK_CODE : com_next[gi*4 +: 4];
        end
    endgenerate

    // Committed digits, displayed digits, frame pulse and blink state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            com_reg        <= {8{BLANK_CODE}};
            disp_reg       <= {8{BLANK_CODE}};
            frame_done_reg <= 1'b0;
            phase_reg      <= 1'b1;
            blink_en_d_reg <= 1'b0;
        end else begin
            com_reg        <= com_next;
            disp_reg       <= disp_next;
            frame_done_reg <= do_commit;
            phase_reg      <= phase_next;
            blink_en_d_reg <= blink_en;
        end
    end

    assign bit_7      = disp_reg[31:28];
    assign bit_6      = disp_reg[27:24];
    assign bit_5      = disp_reg[23:20];
    assign bit_4      = disp_reg[19:16];
    assign bit_3      = disp_reg[15:12];
    assign bit_2      = disp_reg[11:8];
    assign bit_1      = disp_reg[7:4];
    assign bit_0      = disp_reg[3:0];
    assign busy       = (state_reg != ST_IDLE) || conv_busy;
    assign frame_done = frame_done_reg;

endmodule

// File: tb/tb_time_disp_sched.sv
// Bench for time_disp_sched: a frame-level model (43-cycle frame timer,
// decimal digit split, blink overlay) checked every cycle, plus directed
// vectors with literal expectations.
module tb_time_disp_sched;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [5:0] hour, minute, second;
    logic       blink_en, blink_tick;
    logic [1:0] blink_sel;
    logic [3:0] bit_7, bit_6, bit_5, bit_4, bit_3, bit_2, bit_1, bit_0;
    logic       busy, frame_done;
    logic [31:0] dut_digits;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    logic chk_on = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    time_disp_sched dut (
        .clk        (clk),
        .rst        (rst),
        .hour       (hour),
        .minute     (minute),
        .second     (second),
        .blink_en   (blink_en),
        .blink_sel  (blink_sel),
        .blink_tick (blink_tick),
        .bit_7      (bit_7),
        .bit_6      (bit_6),
        .bit_5      (bit_5),
        .bit_4      (bit_4),
        .bit_3      (bit_3),
        .bit_2      (bit_2),
        .bit_1      (bit_1),
        .bit_0      (bit_0),
        .busy       (busy),
        .frame_done (frame_done)
    );

    assign dut_digits = {bit_7, bit_6, bit_5, bit_4, bit_3, bit_2, bit_1, bit_0};

    // ---------------- frame-level model ----------------
    function automatic logic [31:0] frame_digits(input int h, input int m, input int s);
        return {4'(h / 10), 4'(h % 10), 4'd11, 4'(m / 10), 4'(m % 10), 4'd11,
                4'(s / 10), 4'(s % 10)};
    endfunction

    function automatic logic [31:0] overlay(input logic [31:0] d, input logic en,
                                            input logic ph, input logic [1:0] sel);
        logic [31:0] r;
        r = d;
        if (en && !ph) begin
            case (sel)
                2'd0: r[7:0]   = 8'hAA;
                2'd1: r[19:12] = 8'hAA;
                2'd2: r[31:24] = 8'hAA;
                default: ;
            endcase
        end
        return r;
    endfunction

    logic [31:0] m_com, m_disp;
    logic        m_idle, m_pending, m_done, m_phase, m_en_d;
    logic [5:0]  m_lh, m_lm, m_ls, m_sh, m_sm, m_ss;
    int          m_cnt;
    logic        m_start_n, m_commit_n, m_phase_n;

    assign m_start_n  = m_idle && (m_pending || ({hour, minute, second} != {m_sh, m_sm, m_ss}));
    assign m_commit_n = !m_idle && (m_cnt == 42);
    assign m_phase_n  = (blink_en && !m_en_d) ? 1'b1 : (blink_tick ? ~m_phase : m_phase);

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_com     <= 32'hAAAAAAAA;
            m_disp    <= 32'hAAAAAAAA;
            m_idle    <= 1'b1;
            m_pending <= 1'b1;
            m_done    <= 1'b0;
            m_phase   <= 1'b1;
            m_en_d    <= 1'b0;
            m_cnt     <= 0;
            m_lh <= '0; m_lm <= '0; m_ls <= '0;
            m_sh <= '0; m_sm <= '0; m_ss <= '0;
        end else begin
            m_done <= m_commit_n;
            if (m_start_n) begin
                m_lh <= hour; m_lm <= minute; m_ls <= second;
                m_pending <= 1'b0;
                m_idle    <= 1'b0;
                m_cnt     <= 0;
            end else if (m_commit_n) begin
                m_com  <= frame_digits(int'(m_lh), int'(m_lm), int'(m_ls));
                m_sh <= m_lh; m_sm <= m_lm; m_ss <= m_ls;
                m_idle <= 1'b1;
            end else if (!m_idle) begin
                m_cnt <= m_cnt + 1;
            end
            m_phase <= m_phase_n;
            m_en_d  <= blink_en;
            m_disp  <= overlay(m_commit_n ? frame_digits(int'(m_lh), int'(m_lm), int'(m_ls)) : m_com,
                               blink_en, m_phase_n, blink_sel);
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (chk_on) begin
            n_tests++;
            if (dut_digits !== m_disp || busy !== !m_idle || frame_done !== m_done) begin
                n_fail++;
                if (n_fail <= 20)
                    $display("FAIL model_cycle @%0d: got digits=%h busy=%b done=%b, want digits=%h busy=%b done=%b",
                             cyc, dut_digits, busy, frame_done, m_disp, !m_idle, m_done);
            end
        end
    end

    // ---------------- directed helpers ----------------
    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h", name, got, want);
        end
    endtask

    task automatic wait_busy(input string name, output int c0);
        int seen;
        seen = 0;
        c0 = 0;
        for (int i = 0; i < 100 && seen == 0; i++) begin
            @(negedge clk);
            if (busy) begin
                seen = 1;
                c0 = cyc;
            end
        end
        check(name, 32'(seen), 32'd1);
    endtask

    task automatic wait_done(input string name, output logic [31:0] d, output int c1);
        int seen;
        seen = 0;
        d = '0;
        c1 = 0;
        for (int i = 0; i < 200 && seen == 0; i++) begin
            @(negedge clk);
            if (frame_done) begin
                seen = 1;
                d = dut_digits;
                c1 = cyc;
            end
        end
        check(name, 32'(seen), 32'd1);
        if (seen != 0) $display("[TB] %s: frame committed digits=%h at cycle %0d", name, d, c1);
    endtask

    task automatic run_frame(input string name, input logic [5:0] h, input logic [5:0] m,
                             input logic [5:0] s, input logic [31:0] want);
        logic [31:0] d;
        int c1;
        @(posedge clk); #1;
        hour = h; minute = m; second = s;
        wait_done({name, "_done"}, d, c1);
        check(name, d, want);
    endtask

    task automatic tick_pulse();
        @(posedge clk); #1 blink_tick = 1'b1;
        @(posedge clk); #1 blink_tick = 1'b0;
        @(negedge clk);
    endtask

    task automatic set_blink(input logic en, input logic [1:0] sel);
        @(posedge clk); #1;
        blink_en = en; blink_sel = sel;
        @(posedge clk);
        @(negedge clk);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] d;
        int c0, c1, busy_cnt;

        hour = 6'd12; minute = 6'd34; second = 6'd56;
        blink_en = 1'b0; blink_sel = 2'd3; blink_tick = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_digits", dut_digits, 32'hAAAAAAAA);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_done", {31'd0, frame_done}, 32'd0);
        chk_on = 1'b1;
        rst = 1'b1;

        // First frame after reset release.
        wait_busy("first_start", c0);
        wait_done("first_frame_done", d, c1);
        check("first_latency", 32'(c1 - c0), 32'd43);
        check("first_frame", d, 32'h12B34B56);
        @(negedge clk);
        check("first_done_pulse", {31'd0, frame_done}, 32'd0);
        check("first_busy_low", {31'd0, busy}, 32'd0);

        // Steady inputs: no new frame.
        busy_cnt = 0;
        repeat (200) begin
            @(negedge clk);
            if (busy) busy_cnt++;
        end
        check("steady_busy_cycles", 32'(busy_cnt), 32'd0);
        $display("[TB] steady: %0d busy cycles in 200", busy_cnt);

        // Mid-frame change on second.
        @(posedge clk); #1;
        hour = 6'd23; minute = 6'd59; second = 6'd59;
        wait_busy("mid_start", c0);
        repeat (20) @(posedge clk);
        #1 second = 6'd0;
        wait_done("mid_frame1_done", d, c1);
        check("mid_frame1", d, 32'h23B59B59);
        wait_done("mid_frame2_done", d, c1);
        check("mid_frame2", d, 32'h23B59B00);

        // Boundary values.
        run_frame("sec_63",  6'd23, 6'd59, 6'd63, 32'h23B59B63);
        run_frame("sec_0",   6'd23, 6'd59, 6'd0,  32'h23B59B00);
        run_frame("hour_63", 6'd63, 6'd59, 6'd9,  32'h63B59B09);
        run_frame("mix",     6'd7,  6'd40, 6'd9,  32'h07B40B09);

        // Blink overlay.
        set_blink(1'b1, 2'd1);
        check("blink_en_on", dut_digits, 32'h07B40B09);
        tick_pulse();
        check("blink_min_off", dut_digits, 32'h07BAAB09);
        tick_pulse();
        check("blink_min_on", dut_digits, 32'h07B40B09);
        tick_pulse();
        check("blink_min_off2", dut_digits, 32'h07BAAB09);
        set_blink(1'b1, 2'd3);
        check("blink_sel_none", dut_digits, 32'h07B40B09);
        set_blink(1'b1, 2'd2);
        check("blink_hour", dut_digits, 32'hAAB40B09);
        set_blink(1'b1, 2'd0);
        check("blink_sec", dut_digits, 32'h07B40BAA);
        set_blink(1'b0, 2'd0);
        check("blink_disabled", dut_digits, 32'h07B40B09);
        // Phase is off here; an enable rise with a coincident tick must show on.
        @(posedge clk); #1;
        blink_en = 1'b1; blink_sel = 2'd1; blink_tick = 1'b1;
        @(posedge clk); #1 blink_tick = 1'b0;
        @(negedge clk);
        check("rise_beats_tick", dut_digits, 32'h07B40B09);
        set_blink(1'b0, 2'd3);

        // Reset in the middle of a frame.
        @(posedge clk); #1 minute = 6'd15;
        wait_busy("rst_start", c0);
        repeat (20) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        check("rst_mid_digits", dut_digits, 32'hAAAAAAAA);
        check("rst_mid_busy", {31'd0, busy}, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        wait_done("after_rst_done", d, c1);
        check("after_rst", d, 32'h07B15B09);

        repeat (5) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Hard time limit so the run always ends.
    initial begin
        #300000;
        $display("FAIL timeout: simulation did not complete, got no summary, want finish");
        $fatal(1, "timeout");
    end

endmodule
